// File: rtl/common_pkg.sv
// Shared constants, fetch-state type and address helpers for the video fetch path.
// VRAM_BASE/CROM_BASE are 17-bit bus bases; fetch_state_e names the fetch FSM states.
package common_pkg;

  localparam logic [16:0] VRAM_BASE = 17'h08000;
  localparam logic [16:0] CROM_BASE = 17'h10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCR0,
    ST_ROM0,
    ST_SCR1,
    ST_ROM1,
    ST_READY
  } fetch_state_e;

  function automatic logic [16:0] scr_addr(
    input logic [9:0] ma,
    input logic       k
  );
    return VRAM_BASE | {6'd0, ma, k};
  endfunction

  function automatic logic [16:0] rom_addr(
    input logic       gfx,
    input logic [6:0] ch,
    input logic [2:0] ra
  );
    return CROM_BASE | {6'd0, gfx, ch, ra};
  endfunction

endpackage

// File: rtl/video_group_timer.sv
// 16-dot group counter; o_latch fires on the enable that wraps it 15->0.
// Ports: i_clk, i_rst_n (sync, active-low), i_pix_en in; o_latch out (combinational).
module video_group_timer (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_en,
  output logic o_latch
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_pix_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_latch = i_pix_en && (r_cnt == 4'hF);

endmodule

// File: rtl/video_fetch_ctl.sv
// Video fetch controller: reads two screen bytes and their charset rows per group.
// Ports: sys_clock_i/sys_reset_n_i, CRTC ma/ra/de/gfx + pixel enable in;
//   bus_req/addr out, bus_ack/data in; video_latch, pixels, reverse,
//   display_en, fetch_miss out. VIDEO_FETCH_MISS_COUNT_EN adds miss_count_o.
module video_fetch_ctl
  import common_pkg::*;
(
  input  logic        sys_clock_i,
  input  logic        sys_reset_n_i,
  input  logic        pixel_clk_en_i,
  input  logic [9:0]  ma_i,
  input  logic [3:0]  ra_i,
  input  logic        de_i,
  input  logic        gfx_i,
  output logic        bus_req_o,
  output logic [16:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [7:0]  bus_data_i,
  output logic        video_latch_o,
  output logic [15:0] pixels_o,
  output logic [1:0]  reverse_o,
  output logic        display_en_o,
  output logic        fetch_miss_o
`ifdef VIDEO_FETCH_MISS_COUNT_EN
  ,
  output logic [7:0]  miss_count_o
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic        w_latch;
  logic        w_req;
  logic [16:0] w_addr;
  logic        w_take;
  logic        w_load;
  logic        w_miss;

  // group sampled at the last latch
  logic [9:0]  r_ma;
  logic [3:0]  r_ra;
  logic        r_de;
  logic        r_gfx;

  // staged fetch results
  logic [6:0]  r_char;
  logic [7:0]  r_pix0;
  logic [7:0]  r_pix1;
  logic [1:0]  r_rev;

  // displayed group
  logic [15:0] r_pixels;
  logic [1:0]  r_reverse;
  logic        r_disp;
  logic        r_miss;

  video_group_timer u_timer (
    .i_clk    (sys_clock_i),
    .i_rst_n  (sys_reset_n_i),
    .i_pix_en (pixel_clk_en_i),
    .o_latch  (w_latch)
  );

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_addr = 17'd0;
    w_load = 1'b0;
    w_miss = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_next = r_state;
      end
      ST_SCR0: begin
        w_req  = 1'b1;
        w_addr = scr_addr(r_ma, 1'b0);
        if (bus_ack_i) begin
          // row 8..15 is blank: no charset read needed
          w_next = r_ra[3] ? ST_SCR1 : ST_ROM0;
        end
      end
      ST_ROM0: begin
        w_req  = 1'b1;
        w_addr = rom_addr(r_gfx, r_char, r_ra[2:0]);
        if (bus_ack_i) begin
          w_next = ST_SCR1;
        end
      end
      ST_SCR1: begin
        w_req  = 1'b1;
        w_addr = scr_addr(r_ma, 1'b1);
        if (bus_ack_i) begin
          w_next = r_ra[3] ? ST_READY : ST_ROM1;
        end
      end
      ST_ROM1: begin
        w_req  = 1'b1;
        w_addr = rom_addr(r_gfx, r_char, r_ra[2:0]);
        if (bus_ack_i) begin
          w_next = ST_READY;
        end
      end
      ST_READY: begin
        w_next = r_state;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // a latch always wins: restart on the freshly sampled group
    if (w_latch) begin
      w_next = ST_SCR0;
      w_load = (r_state == ST_READY);
      w_miss = (r_state != ST_READY) && (r_state != ST_IDLE);
    end
  end

  assign w_take = w_req && bus_ack_i && !w_latch;

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      r_ma      <= 10'd0;
      r_ra      <= 4'd0;
      r_de      <= 1'b0;
      r_gfx     <= 1'b0;
      r_char    <= 7'd0;
      r_pix0    <= 8'd0;
      r_pix1    <= 8'd0;
      r_rev     <= 2'd0;
      r_pixels  <= 16'd0;
      r_reverse <= 2'd0;
      r_disp    <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_miss <= w_miss;
      if (w_latch) begin
        r_ma  <= ma_i;
        r_ra  <= ra_i;
        r_de  <= de_i;
        r_gfx <= gfx_i;
        if (w_load) begin
          r_pixels  <= {r_pix0, r_pix1};
          r_reverse <= r_rev;
          r_disp    <= r_de;
        end else if (w_miss) begin
          r_pixels  <= 16'd0;
          r_reverse <= 2'd0;
          r_disp    <= 1'b0;
        end
      end else if (w_take) begin
        unique case (r_state)
          ST_SCR0: begin
            r_char   <= bus_data_i[6:0];
            r_rev[0] <= bus_data_i[7];
            if (r_ra[3]) begin
              r_pix0 <= 8'd0;
            end
          end
          ST_ROM0: begin
            r_pix0 <= bus_data_i;
          end
          ST_SCR1: begin
            r_char   <= bus_data_i[6:0];
            r_rev[1] <= bus_data_i[7];
            if (r_ra[3]) begin
              r_pix1 <= 8'd0;
            end
          end
          ST_ROM1: begin
            r_pix1 <= bus_data_i;
          end
          default: begin
            r_char <= r_char;
          end
        endcase
      end
    end
  end

`ifdef VIDEO_FETCH_MISS_COUNT_EN
  logic [7:0] r_miss_cnt;

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      r_miss_cnt <= 8'd0;
    end else if (r_miss && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  assign miss_count_o = r_miss_cnt;
`endif

  assign bus_req_o     = w_req;
  assign bus_addr_o    = w_addr;
  assign video_latch_o = w_latch;
  assign pixels_o      = r_pixels;
  assign reverse_o     = r_reverse;
  assign display_en_o  = r_disp;
  assign fetch_miss_o  = r_miss;

endmodule

// File: tb/tb_video_fetch_ctl.sv
// Randomised and directed bench for video_fetch_ctl against a transaction-level model.
// Define VIDEO_FETCH_MISS_COUNT_EN to also exercise miss_count_o.
module tb_video_fetch_ctl;

  logic        clk;
  logic        rst_n;
  logic        pce;
  logic [9:0]  ma;
  logic [3:0]  ra;
  logic        de;
  logic        gfx;
  logic        req;
  logic [16:0] addr;
  logic        ack;
  logic [7:0]  data;
  logic        latch;
  logic [15:0] pix;
  logic [1:0]  rev;
  logic        den;
  logic        miss;
`ifdef VIDEO_FETCH_MISS_COUNT_EN
  logic [7:0]  mcnt;
`endif

  video_fetch_ctl dut (
    .sys_clock_i    (clk),
    .sys_reset_n_i  (rst_n),
    .pixel_clk_en_i (pce),
    .ma_i           (ma),
    .ra_i           (ra),
    .de_i           (de),
    .gfx_i          (gfx),
    .bus_req_o      (req),
    .bus_addr_o     (addr),
    .bus_ack_i      (ack),
    .bus_data_i     (data),
    .video_latch_o  (latch),
    .pixels_o       (pix),
    .reverse_o      (rev),
    .display_en_o   (den),
    .fetch_miss_o   (miss)
`ifdef VIDEO_FETCH_MISS_COUNT_EN
    ,
    .miss_count_o   (mcnt)
`endif
  );

  logic [7:0] mem [0:131071];
  assign data = mem[addr];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [16:0] mq[$];
  logic [16:0] rd_log[$];
  int          m_cnt = 0;
  bit          started = 0;
  logic [15:0] s_pix;
  logic [1:0]  s_rev;
  logic        s_de;
  logic [15:0] e_pix = 0;
  logic [1:0]  e_rev = 0;
  logic        e_den = 0;
  logic        e_miss = 0;
  int          e_mc = 0;
  int          cyc_n = 0;
  int          n_latch = 0;
  int          miss_seen = 0;

  // driver controls
  bit pce_rand = 0;
  int pce_per = 2;
  int pce_ph = 0;
  bit rand_in = 0;
  bit ack_rand = 0;
  int ack_delay = 0;
  bit collide = 0;
  bit hold_rom0 = 0;
  bit spur = 0;
  int wcnt = 0;
  logic        req_prev = 0;
  logic [16:0] addr_prev = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void build(input logic [9:0] a, input logic [3:0] r,
                                input logic g, input logic d);
    int b0, b1, r0, r1;
    logic [7:0] c0, c1, p0, p1;
    b0 = 'h8000 + 2 * int'(a);
    b1 = b0 + 1;
    c0 = mem[b0];
    c1 = mem[b1];
    r0 = 'h10000 + int'(g) * 1024 + (int'(c0) % 128) * 8 + int'(r) % 8;
    r1 = 'h10000 + int'(g) * 1024 + (int'(c1) % 128) * 8 + int'(r) % 8;
    p0 = 0;
    p1 = 0;
    mq.delete();
    mq.push_back(17'(b0));
    if (r < 8) begin
      mq.push_back(17'(r0));
      p0 = mem[r0];
    end
    mq.push_back(17'(b1));
    if (r < 8) begin
      mq.push_back(17'(r1));
      p1 = mem[r1];
    end
    s_pix = {p0, p1};
    s_rev = {c1[7], c0[7]};
    s_de  = d;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // stimulus driver: pixel enable, CRTC inputs, bus responder
  initial begin
    pce = 0; ma = 0; ra = 0; de = 0; gfx = 0; ack = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pce_rand) begin
        pce = !pce && ($urandom_range(0, 1) == 1);
      end else begin
        pce_ph = (pce_ph + 1) % pce_per;
        pce = (pce_ph == 0);
      end
      if (rand_in) begin
        ma  = 10'($urandom);
        ra  = 4'($urandom);
        de  = 1'($urandom);
        gfx = 1'($urandom);
      end
      if (req) begin
        if (req_prev && addr == addr_prev) wcnt++;
        else wcnt = 0;
        if (collide && mq.size() == 1)
          ack = pce && (m_cnt == 15);
        else if (hold_rom0 && mq.size() == 3)
          ack = 0;
        else if (ack_rand)
          ack = ($urandom_range(0, 2) == 0);
        else
          ack = (wcnt >= ack_delay);
      end else begin
        ack = spur && ($urandom_range(0, 3) == 0);
      end
      req_prev  = req;
      addr_prev = addr;
    end
  end

  // compare process and behavioural model
  always @(negedge clk) begin
    bit lt;
    if (cyc_n > 0) begin
      chk("pixels", 32'(pix), 32'(e_pix));
      chk("reverse", 32'(rev), 32'(e_rev));
      chk("display_en", 32'(den), 32'(e_den));
      chk("fetch_miss", 32'(miss), 32'(e_miss));
      chk("latch", 32'(latch), 32'(pce && m_cnt == 15));
      chk("bus_req", 32'(req), 32'(started && mq.size() > 0));
      if (started && mq.size() > 0) chk("bus_addr", 32'(addr), 32'(mq[0]));
`ifdef VIDEO_FETCH_MISS_COUNT_EN
      chk("miss_count", 32'(mcnt), 32'(e_mc));
`endif
    end
    cyc_n++;
    if (latch) n_latch++;
    if (miss) miss_seen++;
    if (req && ack) rd_log.push_back(addr);
    if (!rst_n) begin
      m_cnt = 0; started = 0; mq.delete();
      e_pix = 0; e_rev = 0; e_den = 0; e_miss = 0; e_mc = 0;
    end else begin
      if (e_miss && e_mc < 255) e_mc++;
      e_miss = 0;
      lt = pce && (m_cnt == 15);
      if (pce) m_cnt = (m_cnt + 1) % 16;
      if (lt) begin
        if (started) begin
          if (mq.size() == 0) begin
            e_pix = s_pix; e_rev = s_rev; e_den = s_de;
          end else begin
            e_pix = 0; e_rev = 0; e_den = 0; e_miss = 1;
          end
        end
        started = 1;
        build(ma, ra, gfx, de);
      end else if (ack && started && mq.size() > 0) begin
        void'(mq.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_latch(input string nm);
    int s;
    s = n_latch;
    for (int i = 0; i < 400; i++) begin
      if (n_latch != s) break;
      cyc(1);
    end
    if (n_latch == s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no latch within 400 cycles", nm);
    end
  endtask

  initial begin
    int m0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[17'h0800A] = 8'h41;
    mem[17'h0800B] = 8'hC2;
    mem[17'h1020A] = 8'hA5;
    mem[17'h10212] = 8'h3C;
    rst_n = 0;
    cyc(3);
    chk("rst_pixels", 32'(pix), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_miss", 32'(miss), 0);
    rst_n = 1;

    // zero-wait fetch of a known group
    ma = 10'h005; ra = 4'd2; gfx = 0; de = 1;
    wait_latch("first_latch");
    chk("first_latch_no_miss", 32'(miss), 0);
    rd_log.delete();
    wait_latch("group1_latch");
    chk("g1_nreads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("g1_rd0", 32'(rd_log[0]), 32'h0800A);
      chk("g1_rd1", 32'(rd_log[1]), 32'h1020A);
      chk("g1_rd2", 32'(rd_log[2]), 32'h0800B);
      chk("g1_rd3", 32'(rd_log[3]), 32'h10212);
    end
    chk("g1_pixels", 32'(pix), 32'hA53C);
    chk("g1_reverse", 32'(rev), 2'b10);
    chk("g1_den", 32'(den), 1);

    // blank raster row: screen reads only
    ra = 4'd9; de = 0;
    wait_latch("blank_l1");
    rd_log.delete();
    wait_latch("blank_l2");
    chk("blank_nreads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("blank_rd0", 32'(rd_log[0]), 32'h0800A);
      chk("blank_rd1", 32'(rd_log[1]), 32'h0800B);
    end
    chk("blank_pixels", 32'(pix), 0);
    chk("blank_reverse", 32'(rev), 2'b10);
    chk("blank_den", 32'(den), 0);

    // slow bus: fetch misses its latch
    ma = 10'h123; ra = 4'd1; de = 1; ack_delay = 20;
    wait_latch("slow_l1");
    wait_latch("slow_l2");
    chk("slow_miss", 32'(miss), 1);
    chk("slow_pixels", 32'(pix), 0);
    chk("slow_den", 32'(den), 0);
    chk("slow_restart_req", 32'(req), 1);
    chk("slow_restart_addr", 32'(addr), 32'h08246);
    cyc(1);
    chk("slow_miss_pulse_end", 32'(miss), 0);

    // ack coinciding with the latch in the last charset read
    ack_delay = 0; collide = 1; ra = 4'd3;
    wait_latch("coll_l1");
    wait_latch("coll_l2");
    chk("coll_miss", 32'(miss), 1);
    chk("coll_pixels", 32'(pix), 0);
    collide = 0;

    // reset while parked in the first charset read
    hold_rom0 = 1;
    for (int i = 0; i < 300; i++) begin
      if (started && mq.size() == 3) break;
      cyc(1);
    end
    chk("reach_rom0", 32'(started && mq.size() == 3), 1);
    rst_n = 0;
    cyc(1);
    chk("midrst_req", 32'(req), 0);
    chk("midrst_pixels", 32'(pix), 0);
    chk("midrst_den", 32'(den), 0);
    rst_n = 1;
    hold_rom0 = 0;
    m0 = miss_seen;
    wait_latch("postrst_l1");
    cyc(2);
    chk("postrst_no_miss", miss_seen - m0, 0);

    // randomised traffic
    rand_in = 1; spur = 1; pce_rand = 1; ack_rand = 1;
    cyc(3000);
    ack_rand = 0;
    for (int k = 0; k < 6; k++) begin
      ack_delay = $urandom_range(0, 9);
      pce_rand = (k % 2 == 0);
      cyc(500);
    end
    rand_in = 0; spur = 0; pce_rand = 0; pce_per = 2;

`ifdef VIDEO_FETCH_MISS_COUNT_EN
    ack_delay = 1000000;
    for (int k = 0; k < 302; k++) wait_latch("sat_latch");
    cyc(2);
    chk("miss_count_sat", 32'(mcnt), 255);
`endif

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_fetch_ctl.md
VIDEO_FETCH_CTL -- requirements
Module: video_fetch_ctl

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-low, with these ports:
  sys_clock_i  in  1  FPGA system clock; sole clock.
  sys_reset_n_i  in  1  synchronous active-low reset.
  pixel_clk_en_i  in  1  pixel clock enable, one sys_clock_i cycle wide.
  ma_i  in  10  CRTC character-pair address.
  ra_i  in  4  CRTC raster row.
  de_i  in  1  CRTC display enable.
  gfx_i  in  1  character set select.
  bus_req_o  out  1  memory read request.
  bus_addr_o  out  17  memory read address.
  bus_ack_i  in  1  read complete; bus_data_i valid this cycle.
  bus_data_i  in  8  read data.
  video_latch_o  out  1  load strobe to the dot generator.
  pixels_o  out  16  two characters of pixels, MSB first.
  reverse_o  out  2  per-character reverse; bit0 = first char, bit1 = second.
  display_en_o  out  1  display enable for the group.
  fetch_miss_o  out  1  one-cycle pulse: group latched before its fetch completed.

Function
REQ-002 SHALL keep a 4-bit group counter, incremented on each pixel_clk_en_i and wrapping 15->0.
REQ-003 SHALL assert video_latch_o combinationally when pixel_clk_en_i is high and the counter is 15; at all other times video_latch_o SHALL be low.
REQ-004 SHALL hold pixels_o, reverse_o and display_en_o stable from the completion of a fetch until the next video_latch_o.
REQ-005 SHALL sample ma_i, ra_i, de_i and gfx_i in every video_latch_o cycle, and SHALL fetch the group presented at the following latch.
REQ-006 SHALL step the FSM through IDLE -> SCR0 -> ROM0 -> SCR1 -> ROM1 -> READY, with each of SCR0..ROM1 advancing only on bus_ack_i.
REQ-007 SHALL compute the SCRk address as VRAM_BASE | {ma, k}, 11-bit offset, where k = 0 or 1.
REQ-008 SHALL compute the ROMk address as CROM_BASE | {gfx, chark[6:0], ra[2:0]}, and SHALL store chark[7] into reverse bit k.
REQ-009 SHALL skip ROMk when ra[3] = 1 and store 8'h00 in that character's pixel byte; reverse bit k still comes from chark[7].
REQ-010 SHALL hold bus_req_o high, and bus_addr_o constant, in SCR0..ROM1 until bus_ack_i; bus_req_o SHALL be low in IDLE and READY.
REQ-011 SHALL treat bus_ack_i outside SCR0..ROM1 as a don't-care that changes no state.
REQ-012 SHALL, on a latch in READY, load the staged data into the outputs, set display_en_o = the sampled de, and go to SCR0.
REQ-013 SHALL, on a latch in any state other than READY (miss):
  - load pixels_o = 0, reverse_o = 0, display_en_o = 0;
  - pulse fetch_miss_o;
  - abandon the fetch in progress and restart at SCR0 with the new sample.
REQ-014 SHALL give latch precedence over bus_ack_i when both arrive in the same cycle in ROM1: the cycle counts as a miss and the acknowledged data is discarded.
REQ-015 SHALL reach a pixel_clk_en_i cadence of 1 in 2 sys_clock_i cycles given zero-wait bus_ack_i (4 reads per 32 cycles).

Reset
REQ-016 SHALL, while sys_reset_n_i is low at a clock edge, set the counter to 0, FSM to IDLE, and all outputs to 0.
REQ-017 SHALL leave IDLE only on the first video_latch_o after reset; that latch is not counted as a miss.
REQ-018 SHALL, when reset is asserted mid-fetch, drop bus_req_o in the next cycle and ignore any later bus_ack_i.

Configuration
REQ-019 SHALL, when VIDEO_FETCH_MISS_COUNT_EN is defined, add output miss_count_o (8 bits): increments on fetch_miss_o, saturates at 255, reset to 0.
REQ-020 SHALL, when VIDEO_FETCH_MISS_COUNT_EN is undefined, omit the miss_count_o port entirely; behaviour is otherwise identical.

Structure
REQ-021 SHALL place VRAM_BASE (17'h08000), CROM_BASE (17'h10000) and the fetch-state enum typedef in common_pkg.
REQ-022 SHALL implement the 4-bit group counter and latch decode as one sub-module, video_group_timer; all other logic is inline.

Verification
REQ-023 SHALL cover these directed scenarios:
  - zero-wait ack, ma=10'h005, ra=2, gfx=0, VRAM 0x800A=0x41, 0x800B=0xC2 -> reads at 0x0800A, 0x1020A, 0x0800B, 0x10212; next latch gives reverse_o=2'b10, display_en_o=de.
  - ra=9 -> only the SCR0 and SCR1 reads are issued; pixels_o=16'h0000.
  - ack delayed 20 cycles per read, pixel_clk_en_i every 2 cycles -> miss at latch: fetch_miss_o=1 for one cycle, outputs zero, FSM restarts at SCR0.
  - ack and latch in the same ROM1 cycle -> counted as a miss, data discarded.
  - reset asserted during ROM0 -> bus_req_o=0 the next cycle, outputs 0, first post-reset latch is not a miss.
  - VIDEO_FETCH_MISS_COUNT_EN defined, 300 forced misses -> miss_count_o=255.
